// File: rtl/stride_out_axis_bridge_if.sv
// ---------------------------------------------------------------------------
// stride_out_axis_bridge_if
//  Ready/valid beat stream with a final-beat marker. One instance carries the
//  feature stream from the stride/output FIFO stage into the bridge, a second
//  instance carries the AXI4-Stream beats from the bridge to the DMA.
//
//  Signals
//   data   DATA_WIDTH  beat payload               (source -> sink)
//   valid  1           source presents a beat     (source -> sink)
//   last   1           final beat marker          (source -> sink)
//   ready  1           sink accepts the beat      (sink -> source)
//
//  Modports
//   master  beat source (drives data/valid/last, observes ready)
//   slave   beat sink   (observes data/valid/last, drives ready)
// ---------------------------------------------------------------------------
interface stride_out_axis_bridge_if #(
    parameter int unsigned DATA_WIDTH = 64
);

    logic [DATA_WIDTH-1:0] data;
    logic                  valid;
    logic                  last;
    logic                  ready;

    modport master (
        output data,
        output valid,
        output last,
        input  ready
    );

    modport slave (
        input  data,
        input  valid,
        input  last,
        output ready
    );

endinterface

// File: rtl/stride_out_axis_bridge.sv
// ---------------------------------------------------------------------------
// stride_out_axis_bridge
//  Downstream neighbour of the stride/output FIFO stage. Accepts the ready/
//  valid feature stream and re-times it onto an AXI4-Stream master for the
//  DMA write channel through a two-entry skid buffer (output register plus
//  skid register), so the upstream ready is a flop and never a combinational
//  function of the DMA tready.
//
//  A layer is armed by a one-cycle start pulse carrying the layer's beat
//  count. The beat count is authoritative: TLAST is attached to the beat whose
//  index is total_beats-1 and the upstream Last flag is only cross-checked
//  against it (sticky err_last). done pulses once, the cycle after the TLAST
//  beat is accepted by the DMA. A start with total_beats==0 produces a done
//  pulse without moving any data.
//
//  Parameters
//   DATA_WIDTH  beat width (matches the AXI data width)
//   CNT_WIDTH   width of the beat counter and total_beats
//
//  Ports
//   clk          clock
//   rst          synchronous, active-high reset; aborts a layer without done
//   start        1-cycle pulse: latch total_beats and arm (ignored while busy)
//   total_beats  beats in this layer
//   s            slave stream from the stride stage (data/valid/last/ready)
//   m_axis       master AXI4-Stream to the DMA (tdata/tvalid/tlast/tready)
//   busy         layer in progress
//   done         1-cycle pulse: final beat accepted by the DMA
//   err_last     sticky: upstream Last disagreed with the beat count
// ---------------------------------------------------------------------------
module stride_out_axis_bridge #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned CNT_WIDTH  = 24
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [CNT_WIDTH-1:0]  total_beats,
    stride_out_axis_bridge_if.slave  s,
    stride_out_axis_bridge_if.master m_axis,
    output logic                  busy,
    output logic                  done,
    output logic                  err_last
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Layer control state
    state_t                 state_q,      state_d;
    logic [CNT_WIDTH-1:0]   total_q,      total_d;
    logic [CNT_WIDTH-1:0]   in_cnt_q,     in_cnt_d;

    // Skid buffer: output register presented to the DMA, skid register behind it
    logic                   out_valid_q,  out_valid_d;
    logic                   out_last_q,   out_last_d;
    logic [DATA_WIDTH-1:0]  out_data_q,   out_data_d;
    logic                   skid_valid_q, skid_valid_d;
    logic                   skid_last_q,  skid_last_d;
    logic [DATA_WIDTH-1:0]  skid_data_q,  skid_data_d;

    // Registered outputs
    logic                   s_ready_q,    s_ready_d;
    logic                   busy_q,       busy_d;
    logic                   done_q,       done_d;
    logic                   err_q,        err_d;

    // Per-cycle qualifiers
    logic                   accept;
    logic                   out_fire;
    logic                   out_free;
    logic                   in_final;

    // Next-state, counting, error tracking and skid-buffer steering
    always_comb begin
        accept   = s.valid & s_ready_q;
        out_fire = out_valid_q & m_axis.ready;
        out_free = ~out_valid_q | m_axis.ready;
        in_final = (in_cnt_q == (total_q - CNT_WIDTH'(1)));

        state_d      = state_q;
        total_d      = total_q;
        in_cnt_d     = in_cnt_q;
        out_valid_d  = out_valid_q;
        out_last_d   = out_last_q;
        out_data_d   = out_data_q;
        skid_valid_d = skid_valid_q;
        skid_last_d  = skid_last_q;
        skid_data_d  = skid_data_q;
        err_d        = err_q;
        done_d       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    err_d = 1'b0;
                    if (total_beats != '0) begin
                        state_d  = RUN;
                        total_d  = total_beats;
                        in_cnt_d = '0;
                    end else begin
                        // Empty layer: nothing to move, report completion
                        done_d = 1'b1;
                    end
                end
            end

            RUN: begin
                if (accept) begin
                    in_cnt_d = in_cnt_q + CNT_WIDTH'(1);
                    // Upstream Last must coincide exactly with the final counted beat
                    if (s.last != in_final) begin
                        err_d = 1'b1;
                    end
                    if (in_final) begin
                        state_d = DRAIN;
                    end
                end
            end

            DRAIN: begin
                // TLAST beat is the youngest beat, so its handshake empties the buffer
                if (out_fire && out_last_q) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Output register refills from the skid entry first to keep beat order
        if (out_free) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_data_d   = skid_data_q;
                out_last_d   = skid_last_q;
                skid_valid_d = accept;
                if (accept) begin
                    skid_data_d = s.data;
                    skid_last_d = in_final;
                end
            end else if (accept) begin
                out_valid_d = 1'b1;
                out_data_d  = s.data;
                out_last_d  = in_final;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept) begin
            // Output stalled: the accepted beat parks in the skid register
            skid_valid_d = 1'b1;
            skid_data_d  = s.data;
            skid_last_d  = in_final;
        end

        // Ready is registered: only offer a slot when the skid entry will be free
        s_ready_d = (state_d == RUN) & ~skid_valid_d;
        busy_d    = (state_d != IDLE);
    end

    // Control and flag registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            total_q      <= '0;
            in_cnt_q     <= '0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_last_q  <= 1'b0;
            s_ready_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            total_q      <= total_d;
            in_cnt_q     <= in_cnt_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
            skid_valid_q <= skid_valid_d;
            skid_last_q  <= skid_last_d;
            s_ready_q    <= s_ready_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    // Beat payload registers; contents only matter while the matching valid is set
    always_ff @(posedge clk) begin
        out_data_q  <= out_data_d;
        skid_data_q <= skid_data_d;
    end

    assign s.ready       = s_ready_q;
    assign m_axis.data   = out_data_q;
    assign m_axis.valid  = out_valid_q;
    assign m_axis.last   = out_last_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign err_last      = err_q;

endmodule
